ysyx_25030093_sram_arbiter: RTL and testbench
=============================================

// Module: ysyx_25030093_sram_arbiter
// PURPOSE
//  Shares one AXI-lite-style SRAM slave between the IFU (read-only master) and the LSU (read/write master).
//  Grants exactly one transaction at a time. The grant is held from request acceptance until the response handshake.
//  Sits between IFU/LSU and the SRAM model. Slave ports plug in where IFU_SRAM_* connected directly.
// PARAMETERS
//  AW  32  address width
//  DW  32  data width (wstrb width = DW/8)
// PORTS
//  clk                        in   1      system clock, all logic on posedge
//  rst                        in   1      async reset, ACTIVE-LOW
//  IFU_ARB_araddr/arvalid     in   AW/1   IFU read address channel
//  ARB_IFU_arready            out  1      IFU AR accepted
//  ARB_IFU_rdata/rvalid       out  DW/1   IFU read data channel
//  IFU_ARB_rready             in   1      IFU R ready
//  LSU_ARB_araddr/arvalid     in   AW/1   LSU read address channel
//  ARB_LSU_arready            out  1      LSU AR accepted
//  ARB_LSU_rdata/rvalid       out  DW/1   LSU read data channel
//  LSU_ARB_rready             in   1      LSU R ready
//  LSU_ARB_awaddr/wdata/wstrb/wvalid  in  AW/DW/DW/8/1  LSU combined write addr+data channel
//  ARB_LSU_wready             out  1      LSU write accepted
//  ARB_LSU_bvalid             out  1      LSU write response valid
//  LSU_ARB_bready             in   1      LSU B ready
//  ARB_SRAM_araddr/arvalid    out  AW/1   slave AR channel
//  SRAM_ARB_arready           in   1
//  SRAM_ARB_rdata/rvalid      in   DW/1   slave R channel
//  ARB_SRAM_rready            out  1
//  ARB_SRAM_awaddr/wdata/wstrb/wvalid  out  AW/DW/DW/8/1  slave write channel
//  SRAM_ARB_wready            in   1
//  SRAM_ARB_bvalid            in   1      slave B channel
//  ARB_SRAM_bready            out  1
// BEHAVIOUR
//  - FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR. A separate 1-bit req_done flag tracks address-phase completion.
//  - Reset (rst=0, async): state=IDLE, req_done=0, last_grant=LSU.
//    All valid/ready outputs are 0; data/addr outputs are 0.
//  - IDLE: no output valid/ready is asserted. The FSM samples requests and moves to the owner state on the next posedge.
//    Arbitration therefore costs 1 cycle of latency.
//  - LSU request priority: wvalid beats arvalid.
//  - Owner state, address phase (req_done=0):
//    - Owner address/data/strb/valid are forwarded combinationally to the slave.
//    - Slave ready is returned only to the owner. Every non-owner ready is 0.
//  - When the AR/W handshake fires (valid&ready): req_done<=1.
//    From then on, slave arvalid/wvalid is forced to 0.
//  - Response phase:
//    - Slave rvalid/bvalid and rdata are routed to the owner.
//    - The owner's rready/bready is routed to the slave.
//    - Non-owner rvalid/bvalid is 0. Non-owner rdata holds 0.
//  - On the R or B handshake: state<=IDLE, req_done<=0, last_grant<=owner.
//    At least one IDLE cycle separates consecutive grants.
//  - Back-to-back handshake (address and response in the same cycle): both take effect and the FSM returns to IDLE.
//  - Masters must hold valid and payload stable until ready. The arbiter never drops a granted valid.
//  - Requests arriving while another owner is busy wait with ready=0 and are served in a later IDLE arbitration.
//  - Reset asserted mid-transaction: immediate return to IDLE. The outstanding transfer is abandoned, with no response to either master.
// CONFIGURATION
//  ARB_RR_EN
//  - Undefined: fixed priority, LSU > IFU. The IFU may starve under continuous LSU traffic.
//  - Defined: round-robin between IFU and LSU using last_grant.
//    When both request in IDLE, the master that did NOT own the last grant wins.
//    After reset, the IFU wins the first conflict.
// TESTING
//  1. Reset release; IFU arvalid=1, araddr=0x8000_0000; slave arready=1, rdata=0x0000_0413 after 1 cycle.
//     -> ARB_SRAM_araddr=0x8000_0000 one cycle after the request; IFU receives rvalid with 0x413; LSU readies stay 0.
//  2. IFU and LSU read (0x8000_0100) requested in the same IDLE cycle.
//     -> default build: LSU granted first, then IFU.
//     -> ARB_RR_EN build after reset: IFU first, then LSU.
//  3. LSU write awaddr=0x8000_0200, wdata=0xDEADBEEF, wstrb=4'b0011; slave wready after a 3-cycle stall.
//     -> slave sees a stable payload for all 4 cycles; ARB_LSU_bvalid follows SRAM bvalid; the FSM then returns to IDLE.
//  4. IFU granted, slave rvalid held 5 cycles with IFU rready=0.
//     -> LSU arvalid meanwhile sees arready=0; LSU is granted only after the IFU R handshake plus 1 IDLE cycle.
//  5. Drive rst=0 asynchronously during a granted read that is waiting on rvalid.
//     -> all outputs go to 0 within the same cycle; after release, a new IFU read completes normally.
//  6. ARB_RR_EN build, IFU and LSU both request continuously for 10 transactions.
//     -> grants alternate IFU/LSU/IFU..., 5 each.

Source files
------------

// File: rtl/ysyx_25030093_sram_arbiter.sv
// Two-master (IFU read-only, LSU read/write) arbiter in front of one AXI-lite-style SRAM slave.
// Optional macro ARB_RR_EN selects round-robin arbitration; without it LSU has fixed priority.
module ysyx_25030093_sram_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic [AW-1:0]   IFU_ARB_araddr,
    input  logic            IFU_ARB_arvalid,
    output logic            ARB_IFU_arready,
    output logic [DW-1:0]   ARB_IFU_rdata,
    output logic            ARB_IFU_rvalid,
    input  logic            IFU_ARB_rready,

    input  logic [AW-1:0]   LSU_ARB_araddr,
    input  logic            LSU_ARB_arvalid,
    output logic            ARB_LSU_arready,
    output logic [DW-1:0]   ARB_LSU_rdata,
    output logic            ARB_LSU_rvalid,
    input  logic            LSU_ARB_rready,
    input  logic [AW-1:0]   LSU_ARB_awaddr,
    input  logic [DW-1:0]   LSU_ARB_wdata,
    input  logic [DW/8-1:0] LSU_ARB_wstrb,
    input  logic            LSU_ARB_wvalid,
    output logic            ARB_LSU_wready,
    output logic            ARB_LSU_bvalid,
    input  logic            LSU_ARB_bready,

    output logic [AW-1:0]   ARB_SRAM_araddr,
    output logic            ARB_SRAM_arvalid,
    input  logic            SRAM_ARB_arready,
    input  logic [DW-1:0]   SRAM_ARB_rdata,
    input  logic            SRAM_ARB_rvalid,
    output logic            ARB_SRAM_rready,
    output logic [AW-1:0]   ARB_SRAM_awaddr,
    output logic [DW-1:0]   ARB_SRAM_wdata,
    output logic [DW/8-1:0] ARB_SRAM_wstrb,
    output logic            ARB_SRAM_wvalid,
    input  logic            SRAM_ARB_wready,
    input  logic            SRAM_ARB_bvalid,
    output logic            ARB_SRAM_bready
);

    typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

    state_t state, state_nxt;
    logic   req_done;
    logic   ifu_wins;
    logic   addr_hs;
    logic   resp_hs;

`ifdef ARB_RR_EN
    logic   last_lsu;

    // On a conflict the master that did not own the previous grant goes first
    always_comb begin
        ifu_wins = IFU_ARB_arvalid & (~(LSU_ARB_arvalid | LSU_ARB_wvalid) | last_lsu);
    end
`else
    always_comb begin
        ifu_wins = IFU_ARB_arvalid & ~(LSU_ARB_arvalid | LSU_ARB_wvalid);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            req_done <= 1'b0;
`ifdef ARB_RR_EN
            last_lsu <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (resp_hs) begin
                req_done <= 1'b0;
            end else if (addr_hs) begin
                req_done <= 1'b1;
            end
`ifdef ARB_RR_EN
            if (resp_hs) begin
                last_lsu <= (state != IFU_RD);
            end
`endif
        end
    end

    always_comb begin
        state_nxt        = state;
        ARB_IFU_arready  = 1'b0;
        ARB_IFU_rdata    = '0;
        ARB_IFU_rvalid   = 1'b0;
        ARB_LSU_arready  = 1'b0;
        ARB_LSU_rdata    = '0;
        ARB_LSU_rvalid   = 1'b0;
        ARB_LSU_wready   = 1'b0;
        ARB_LSU_bvalid   = 1'b0;
        ARB_SRAM_araddr  = '0;
        ARB_SRAM_arvalid = 1'b0;
        ARB_SRAM_rready  = 1'b0;
        ARB_SRAM_awaddr  = '0;
        ARB_SRAM_wdata   = '0;
        ARB_SRAM_wstrb   = '0;
        ARB_SRAM_wvalid  = 1'b0;
        ARB_SRAM_bready  = 1'b0;

        case (state)
            IDLE: begin
                // Write requests take precedence over reads within the LSU
                if (ifu_wins) begin
                    state_nxt = IFU_RD;
                end else if (LSU_ARB_wvalid) begin
                    state_nxt = LSU_WR;
                end else if (LSU_ARB_arvalid) begin
                    state_nxt = LSU_RD;
                end
            end
            IFU_RD: begin
                ARB_SRAM_araddr  = IFU_ARB_araddr;
                ARB_SRAM_arvalid = IFU_ARB_arvalid & ~req_done;
                ARB_IFU_arready  = SRAM_ARB_arready & ~req_done;
                ARB_IFU_rdata    = SRAM_ARB_rdata;
                ARB_IFU_rvalid   = SRAM_ARB_rvalid;
                ARB_SRAM_rready  = IFU_ARB_rready;
            end
            LSU_RD: begin
                ARB_SRAM_araddr  = LSU_ARB_araddr;
                ARB_SRAM_arvalid = LSU_ARB_arvalid & ~req_done;
                ARB_LSU_arready  = SRAM_ARB_arready & ~req_done;
                ARB_LSU_rdata    = SRAM_ARB_rdata;
                ARB_LSU_rvalid   = SRAM_ARB_rvalid;
                ARB_SRAM_rready  = LSU_ARB_rready;
            end
            LSU_WR: begin
                ARB_SRAM_awaddr  = LSU_ARB_awaddr;
                ARB_SRAM_wdata   = LSU_ARB_wdata;
                ARB_SRAM_wstrb   = LSU_ARB_wstrb;
                ARB_SRAM_wvalid  = LSU_ARB_wvalid & ~req_done;
                ARB_LSU_wready   = SRAM_ARB_wready & ~req_done;
                ARB_LSU_bvalid   = SRAM_ARB_bvalid;
                ARB_SRAM_bready  = LSU_ARB_bready;
            end
            default: state_nxt = IDLE;
        endcase

        addr_hs = (ARB_SRAM_arvalid & SRAM_ARB_arready) | (ARB_SRAM_wvalid & SRAM_ARB_wready);
        resp_hs = (ARB_SRAM_rready & SRAM_ARB_rvalid) | (ARB_SRAM_bready & SRAM_ARB_bvalid);
        // A response handshake ends the grant even if the address phase completes in the same cycle
        if (resp_hs) begin
            state_nxt = IDLE;
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_sram_arbiter.sv
// Bench for ysyx_25030093_sram_arbiter: arbitration table, directed corner sequences and
// randomized traffic against a transaction-level model (honours ARB_RR_EN when defined).
module tb_ysyx_25030093_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata, s_rdata;
    logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready, lsu_wvalid, lsu_bready;
    logic [3:0]  lsu_wstrb;
    logic        s_arready, s_rvalid, s_wready, s_bvalid;

    logic [31:0] ifu_rdata, lsu_rdata, sram_araddr, sram_awaddr, sram_wdata;
    logic [3:0]  sram_wstrb;
    logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_wready, lsu_bvalid;
    logic        sram_arvalid, sram_rready, sram_wvalid, sram_bready;

    ysyx_25030093_sram_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .IFU_ARB_araddr(ifu_araddr), .IFU_ARB_arvalid(ifu_arvalid), .ARB_IFU_arready(ifu_arready),
        .ARB_IFU_rdata(ifu_rdata), .ARB_IFU_rvalid(ifu_rvalid), .IFU_ARB_rready(ifu_rready),
        .LSU_ARB_araddr(lsu_araddr), .LSU_ARB_arvalid(lsu_arvalid), .ARB_LSU_arready(lsu_arready),
        .ARB_LSU_rdata(lsu_rdata), .ARB_LSU_rvalid(lsu_rvalid), .LSU_ARB_rready(lsu_rready),
        .LSU_ARB_awaddr(lsu_awaddr), .LSU_ARB_wdata(lsu_wdata), .LSU_ARB_wstrb(lsu_wstrb),
        .LSU_ARB_wvalid(lsu_wvalid), .ARB_LSU_wready(lsu_wready), .ARB_LSU_bvalid(lsu_bvalid),
        .LSU_ARB_bready(lsu_bready),
        .ARB_SRAM_araddr(sram_araddr), .ARB_SRAM_arvalid(sram_arvalid), .SRAM_ARB_arready(s_arready),
        .SRAM_ARB_rdata(s_rdata), .SRAM_ARB_rvalid(s_rvalid), .ARB_SRAM_rready(sram_rready),
        .ARB_SRAM_awaddr(sram_awaddr), .ARB_SRAM_wdata(sram_wdata), .ARB_SRAM_wstrb(sram_wstrb),
        .ARB_SRAM_wvalid(sram_wvalid), .SRAM_ARB_wready(s_wready), .SRAM_ARB_bvalid(s_bvalid),
        .ARB_SRAM_bready(sram_bready)
    );

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(string nm, logic [199:0] act, logic [199:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    // ---------------- reference model ----------------
    localparam int O_NONE = 0, O_IFU = 1, O_LRD = 2, O_LWR = 3;
    int m_own;
    bit m_done;
    bit m_last_lsu;

    typedef struct packed {
        logic        ifu_arready; logic ifu_rvalid; logic [31:0] ifu_rdata;
        logic        lsu_arready; logic lsu_rvalid; logic [31:0] lsu_rdata;
        logic        lsu_wready;  logic lsu_bvalid;
        logic        sram_arvalid; logic sram_rready; logic sram_wvalid; logic sram_bready;
        logic [31:0] araddr; logic [31:0] awaddr; logic [31:0] wdata; logic [3:0] wstrb;
    } out_t;

    function automatic int pick(bit i, bit r, bit w, bit last_lsu);
        int lsu_kind;
        lsu_kind = w ? O_LWR : O_LRD;
        if (!i && !r && !w) return O_NONE;
        if (!r && !w) return O_IFU;
        if (!i) return lsu_kind;
`ifdef ARB_RR_EN
        return last_lsu ? O_IFU : lsu_kind;
`else
        return lsu_kind;
`endif
    endfunction

    function automatic out_t model_out();
        out_t e;
        e = '0;
        if (m_own == O_IFU) begin
            e.sram_arvalid = ifu_arvalid & !m_done;
            e.ifu_arready  = s_arready & !m_done;
            e.ifu_rvalid   = s_rvalid;
            e.ifu_rdata    = s_rdata;
            e.sram_rready  = ifu_rready;
            if (e.sram_arvalid) e.araddr = ifu_araddr;
        end else if (m_own == O_LRD) begin
            e.sram_arvalid = lsu_arvalid & !m_done;
            e.lsu_arready  = s_arready & !m_done;
            e.lsu_rvalid   = s_rvalid;
            e.lsu_rdata    = s_rdata;
            e.sram_rready  = lsu_rready;
            if (e.sram_arvalid) e.araddr = lsu_araddr;
        end else if (m_own == O_LWR) begin
            e.sram_wvalid  = lsu_wvalid & !m_done;
            e.lsu_wready   = s_wready & !m_done;
            e.lsu_bvalid   = s_bvalid;
            e.sram_bready  = lsu_bready;
            if (e.sram_wvalid) begin
                e.awaddr = lsu_awaddr; e.wdata = lsu_wdata; e.wstrb = lsu_wstrb;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    bit hs_ifu_ar, hs_ifu_r, hs_lsu_ar, hs_lsu_r, hs_lsu_w, hs_lsu_b, hs_s_ar, hs_s_w, hs_s_r, hs_s_b;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;

    // Called just after inputs are driven on the falling edge; checks and advances the model.
    task automatic step_check();
        out_t e, a;
        #1;
        e = model_out();
        a = '{ifu_arready, ifu_rvalid, ifu_rdata, lsu_arready, lsu_rvalid, lsu_rdata,
              lsu_wready, lsu_bvalid, sram_arvalid, sram_rready, sram_wvalid, sram_bready,
              32'h0, 32'h0, 32'h0, 4'h0};
        if (e.sram_arvalid) a.araddr = sram_araddr;
        if (e.sram_wvalid) begin
            a.awaddr = sram_awaddr; a.wdata = sram_wdata; a.wstrb = sram_wstrb;
        end
        chk("cycle", a, e);
        hs_ifu_ar = ifu_arvalid & ifu_arready;  hs_ifu_r = ifu_rvalid & ifu_rready;
        hs_lsu_ar = lsu_arvalid & lsu_arready;  hs_lsu_r = lsu_rvalid & lsu_rready;
        hs_lsu_w  = lsu_wvalid & lsu_wready;    hs_lsu_b = lsu_bvalid & lsu_bready;
        hs_s_ar   = sram_arvalid & s_arready;   hs_s_w   = sram_wvalid & s_wready;
        hs_s_r    = s_rvalid & sram_rready;     hs_s_b   = s_bvalid & sram_bready;
        cap_araddr = sram_araddr; cap_awaddr = sram_awaddr;
        cap_wdata  = sram_wdata;  cap_wstrb  = sram_wstrb;
        if (m_own == O_NONE) begin
            m_own = pick(ifu_arvalid, lsu_arvalid, lsu_wvalid, m_last_lsu);
        end else if ((e.ifu_rvalid & ifu_rready) | (e.lsu_rvalid & lsu_rready) | (e.lsu_bvalid & lsu_bready)) begin
            m_last_lsu = (m_own != O_IFU);
            m_own = O_NONE;
            m_done = 1'b0;
        end else if ((e.sram_arvalid & s_arready) | (e.sram_wvalid & s_wready)) begin
            m_done = 1'b1;
        end
    endtask

    task automatic clear_inputs();
        ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
        lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
        lsu_awaddr = '0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0; lsu_bready = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_wready = 0; s_bvalid = 0;
    endtask

    task automatic model_reset();
        m_own = O_NONE; m_done = 1'b0; m_last_lsu = 1'b1;
    endtask

    // Leaves the bench on a falling edge with reset just released.
    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        step_check();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ---------------- traffic generator (masters + slave) ----------------
    logic [31:0] ref_mem [16];
    logic [31:0] s_mem   [16];
    bit          i_act, i_acc, l_act, l_acc, l_wr, sb_busy, sb_wr;
    logic [31:0] i_addr, l_addr, l_data;
    logic [3:0]  l_strb;
    int          sb_idx, sb_delay;
    int          n_ifu_done, n_lsu_done;
    bit          grants[$];

    task automatic run_traffic(int cycles, bit busy);
        bit busy_before;
        i_act = 0; l_act = 0; sb_busy = 0; n_ifu_done = 0; n_lsu_done = 0;
        grants.delete();
        for (int c = 0; c < cycles; c++) begin
            if (!i_act && (busy || $urandom_range(0, 3) == 0)) begin
                i_act = 1; i_acc = 0; i_addr = 32'h8000_0000 | ($urandom_range(0, 15) << 2);
            end
            if (!l_act && (busy || $urandom_range(0, 2) == 0)) begin
                l_act = 1; l_acc = 0; l_wr = ($urandom_range(0, 1) == 1);
                l_addr = 32'h8000_0000 | ($urandom_range(0, 15) << 2);
                l_data = $urandom; l_strb = 4'($urandom_range(0, 15));
            end
            ifu_arvalid = i_act & !i_acc; ifu_araddr = i_addr;
            ifu_rready  = busy | ($urandom_range(0, 1) == 1);
            lsu_arvalid = l_act & !l_wr & !l_acc; lsu_araddr = l_addr;
            lsu_wvalid  = l_act & l_wr & !l_acc;  lsu_awaddr = l_addr;
            lsu_wdata = l_data; lsu_wstrb = l_strb;
            lsu_rready = busy | ($urandom_range(0, 1) == 1);
            lsu_bready = busy | ($urandom_range(0, 1) == 1);
            s_arready = !sb_busy & (busy | ($urandom_range(0, 1) == 1));
            s_wready  = !sb_busy & (busy | ($urandom_range(0, 1) == 1));
            s_rvalid  = sb_busy & !sb_wr & (sb_delay == 0);
            s_bvalid  = sb_busy & sb_wr & (sb_delay == 0);
            s_rdata   = s_rvalid ? s_mem[sb_idx] : $urandom;
            step_check();
            if (hs_ifu_ar) grants.push_back(1'b0);
            if (hs_lsu_ar | hs_lsu_w) grants.push_back(1'b1);
            if (hs_ifu_ar) i_acc = 1;
            if (hs_ifu_r && i_act && i_acc) begin
                chk("ifu_rdata", ifu_rdata, ref_mem[i_addr[5:2]]);
                i_act = 0; n_ifu_done++;
            end
            if (hs_lsu_ar | hs_lsu_w) l_acc = 1;
            if (hs_lsu_r && l_act && l_acc && !l_wr) begin
                chk("lsu_rdata", lsu_rdata, ref_mem[l_addr[5:2]]);
                l_act = 0; n_lsu_done++;
            end
            if (hs_lsu_b && l_act && l_acc && l_wr) begin
                ref_mem[l_addr[5:2]] = merge(ref_mem[l_addr[5:2]], l_data, l_strb);
                l_act = 0; n_lsu_done++;
            end
            busy_before = sb_busy;
            if (busy_before) begin
                if ((s_rvalid && hs_s_r) || (s_bvalid && hs_s_b)) sb_busy = 0;
                else if (sb_delay > 0) sb_delay--;
            end else if (hs_s_ar) begin
                sb_busy = 1; sb_wr = 0; sb_idx = int'(cap_araddr[5:2]);
                sb_delay = busy ? 0 : $urandom_range(0, 3);
            end else if (hs_s_w) begin
                sb_busy = 1; sb_wr = 1; sb_idx = int'(cap_awaddr[5:2]);
                s_mem[sb_idx] = merge(s_mem[sb_idx], cap_wdata, cap_wstrb);
                sb_delay = busy ? 0 : $urandom_range(0, 3);
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        bit         i, r, w;
        logic [4:0] exp;   // {ifu_arready, lsu_arready, lsu_wready, sram_arvalid, sram_wvalid}
    } arb_vec_t;

    initial begin
        arb_vec_t tbl [8];
        bit exp_g;
        tbl[0] = '{1, 0, 0, 5'b10010};
        tbl[1] = '{0, 1, 0, 5'b01010};
        tbl[2] = '{0, 0, 1, 5'b00101};
        tbl[3] = '{0, 1, 1, 5'b00101};
        tbl[4] = '{0, 0, 0, 5'b00000};
`ifdef ARB_RR_EN
        tbl[5] = '{1, 1, 0, 5'b10010};
        tbl[6] = '{1, 0, 1, 5'b10010};
        tbl[7] = '{1, 1, 1, 5'b10010};
`else
        tbl[5] = '{1, 1, 0, 5'b01010};
        tbl[6] = '{1, 0, 1, 5'b00101};
        tbl[7] = '{1, 1, 1, 5'b00101};
`endif
        for (int k = 0; k < 16; k++) begin
            ref_mem[k] = 32'h1000_0000 + k * 32'h0101_0101;
            s_mem[k]   = ref_mem[k];
        end
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(negedge clk);

        // Arbitration decisions from IDLE right after reset
        for (int v = 0; v < 8; v++) begin
            do_reset();
            ifu_arvalid = tbl[v].i; ifu_araddr = 32'h8000_0010;
            lsu_arvalid = tbl[v].r; lsu_araddr = 32'h8000_0110;
            lsu_wvalid  = tbl[v].w; lsu_awaddr = 32'h8000_0210;
            lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011;
            s_arready = 1; s_wready = 1;
            step_check();
            @(negedge clk);
            step_check();
            chk("arb_tbl", {ifu_arready, lsu_arready, lsu_wready, sram_arvalid, sram_wvalid}, tbl[v].exp);
        end

        // Single IFU read: one cycle of arbitration latency, data routed back
        do_reset();
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1; s_arready = 1; ifu_rready = 1;
        step_check();
        chk("t1_idle", sram_arvalid, 1'b0);
        @(negedge clk);
        step_check();
        chk("t1_ar", {sram_arvalid, sram_araddr, lsu_arready, lsu_wready}, {1'b1, 32'h8000_0000, 2'b00});
        @(negedge clk);
        ifu_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_0413;
        step_check();
        chk("t1_r", {ifu_rvalid, ifu_rdata, lsu_rvalid}, {1'b1, 32'h0000_0413, 1'b0});
        @(negedge clk);
        s_rvalid = 0;
        step_check();

        // Write with a 3-cycle wready stall: payload held to the slave throughout
        do_reset();
        lsu_awaddr = 32'h8000_0200; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011; lsu_wvalid = 1;
        lsu_bready = 1;
        step_check();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s_wready = (k == 3);
            step_check();
            chk("t3_payload", {sram_wvalid, sram_awaddr, sram_wdata, sram_wstrb, lsu_wready},
                {1'b1, 32'h8000_0200, 32'hDEAD_BEEF, 4'b0011, (k == 3)});
        end
        @(negedge clk);
        lsu_wvalid = 0; s_wready = 0; s_bvalid = 1;
        step_check();
        chk("t3_b", {lsu_bvalid, sram_bready, sram_wvalid}, 3'b110);
        @(negedge clk);
        s_bvalid = 0;
        step_check();
        chk("t3_idle", {lsu_bvalid, lsu_wready, sram_wvalid}, 3'b000);

        // IFU holds the grant while rready stays low; LSU waits, then gets a grant after one IDLE cycle
        do_reset();
        ifu_araddr = 32'h8000_0004; ifu_arvalid = 1; s_arready = 1;
        step_check();
        @(negedge clk);
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0100;
        step_check();
        chk("t4_lsu_wait", lsu_arready, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ifu_arvalid = 0; s_rvalid = 1; s_rdata = 32'h0000_1234; ifu_rready = (k == 5);
            step_check();
            chk("t4_lsu_wait", {lsu_arready, ifu_rvalid}, 2'b01);
        end
        @(negedge clk);
        s_rvalid = 0; ifu_rready = 0;
        step_check();
        chk("t4_idle_gap", lsu_arready, 1'b0);
        @(negedge clk);
        step_check();
        chk("t4_lsu_grant", {lsu_arready, sram_arvalid, sram_araddr}, {2'b11, 32'h8000_0100});

        // Asynchronous reset while a read waits on its response
        do_reset();
        ifu_araddr = 32'h8000_0008; ifu_arvalid = 1; s_arready = 1;
        step_check();
        @(negedge clk);
        step_check();
        @(negedge clk);
        ifu_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_0055; ifu_rready = 0;
        step_check();
        chk("t5_pre", {ifu_rvalid, ifu_rdata}, {1'b1, 32'h0000_0055});
        #2 rst = 1'b0;
        #1;
        chk("t5_async", {ifu_arready, ifu_rvalid, ifu_rdata, lsu_arready, lsu_rvalid, lsu_rdata,
                         lsu_wready, lsu_bvalid, sram_araddr, sram_arvalid, sram_rready,
                         sram_awaddr, sram_wdata, sram_wstrb, sram_wvalid, sram_bready}, '0);
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        ifu_araddr = 32'h8000_000C; ifu_arvalid = 1; s_arready = 1;
        step_check();
        @(negedge clk);
        step_check();
        @(negedge clk);
        ifu_arvalid = 0; s_arready = 0; s_rvalid = 1; s_rdata = 32'h0000_0077; ifu_rready = 1;
        step_check();
        chk("t5_after", {ifu_rvalid, ifu_rdata}, {1'b1, 32'h0000_0077});
        @(negedge clk);
        clear_inputs();
        step_check();

        // Both masters request continuously: grant order from reset
        do_reset();
        run_traffic(40, 1'b1);
        chk("grant_count", grants.size() >= 10, 1'b1);
        for (int k = 0; k < 10 && k < grants.size(); k++) begin
`ifdef ARB_RR_EN
            exp_g = (k % 2 == 1);
`else
            exp_g = 1'b1;
`endif
            chk("grant_order", grants[k], exp_g);
        end

        // Randomized mixed traffic with a variable-latency slave
        do_reset();
        run_traffic(3000, 1'b0);
        chk("ifu_served", n_ifu_done > 20, 1'b1);
        chk("lsu_served", n_lsu_done > 20, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
